// File: rtl/retire_rat.sv
// Retirement RAT: records committed arch->phys mappings, frees the displaced physical register,
// and streams the committed map back to the front-end RAT after a flush. Optional: RRAT_MAP_CHECK_EN.
module retire_rat #(
   parameter int ARCH_REGS     = 32,
   parameter int PHYS_REG_ADDR = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             commit_valid,
   input  logic [$clog2(ARCH_REGS)-1:0]     commit_arch_rd,
   input  logic [PHYS_REG_ADDR-1:0]         commit_phys_rd,
   input  logic                             flush,
   output logic                             free_w_en,
   output logic [PHYS_REG_ADDR-1:0]         freed_physical_reg,
   output logic                             restore_valid,
   output logic [$clog2(ARCH_REGS)-1:0]     restore_arch,
   output logic [PHYS_REG_ADDR-1:0]         restore_phys,
   output logic                             restore_busy,
   output logic                             map_err
);

   localparam int ARCH_W = $clog2(ARCH_REGS);
   localparam logic [ARCH_W-1:0] LAST_BEAT = ARCH_W'(ARCH_REGS - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } state_e;

   state_e                   r_state, w_state_nxt;
   logic [ARCH_W-1:0]        r_cnt, w_cnt_nxt;
   logic [PHYS_REG_ADDR-1:0] r_map [ARCH_REGS];

   logic                     w_commit;
   logic                     w_free;
   logic                     w_beat;
   logic [ARCH_W-1:0]        w_beat_arch;

   logic                     r_free_w_en;
   logic [PHYS_REG_ADDR-1:0] r_freed;
   logic                     r_restore_valid;
   logic [ARCH_W-1:0]        r_restore_arch;
   logic [PHYS_REG_ADDR-1:0] r_restore_phys;
   logic                     r_restore_busy;

   // A flush-cycle commit still lands in the map; only its free write is dropped.
   assign w_commit = commit_valid && (commit_arch_rd != '0) && ((r_state == IDLE) || flush);
   assign w_free   = w_commit && !flush;

   // r_cnt holds the index of the next beat to emit; a flush emits beat 0 at its own edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_beat      = 1'b0;
      w_beat_arch = r_cnt;
      if (flush) begin
         w_state_nxt = RESTORE;
         w_cnt_nxt   = ARCH_W'(1);
         w_beat      = 1'b1;
         w_beat_arch = '0;
      end else if (r_state == RESTORE) begin
         w_beat    = 1'b1;
         w_cnt_nxt = r_cnt + ARCH_W'(1);
         if (r_cnt == LAST_BEAT) begin
            w_state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: this array is reset on purpose -- the identity mapping is architectural state, not scratch storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_map[i] <= PHYS_REG_ADDR'(i);
         end
      end else if (w_commit) begin
         r_map[commit_arch_rd] <= commit_phys_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_free_w_en     <= 1'b0;
         r_freed         <= '0;
         r_restore_valid <= 1'b0;
         r_restore_arch  <= '0;
         r_restore_phys  <= '0;
         r_restore_busy  <= 1'b0;
      end else begin
         r_free_w_en     <= w_free;
         r_freed         <= w_free ? r_map[commit_arch_rd] : '0;
         r_restore_valid <= w_beat;
         r_restore_arch  <= w_beat ? w_beat_arch : '0;
         r_restore_phys  <= w_beat ? r_map[w_beat_arch] : '0;
         r_restore_busy  <= w_beat;
      end
   end

   assign free_w_en          = r_free_w_en;
   assign freed_physical_reg = r_freed;
   assign restore_valid      = r_restore_valid;
   assign restore_arch       = r_restore_arch;
   assign restore_phys       = r_restore_phys;
   assign restore_busy       = r_restore_busy;

`ifdef RRAT_MAP_CHECK_EN
   localparam int PHYS_REGS = 2 ** PHYS_REG_ADDR;

   logic [PHYS_REGS-1:0] r_mapped;
   logic                 r_map_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mapped  <= {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
         r_map_err <= 1'b0;
      end else begin
         r_map_err <= w_commit && (r_mapped[commit_phys_rd] || (commit_phys_rd == '0));
         if (w_commit) begin
            // Set after clear so a commit re-installing the same register keeps its bit.
            r_mapped[r_map[commit_arch_rd]] <= 1'b0;
            r_mapped[commit_phys_rd]        <= 1'b1;
         end
      end
   end

   assign map_err = r_map_err;
`else
   assign map_err = 1'b0;
`endif

endmodule
